// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer controller for the dual-clock gray-pointer FIFO.
// Define FIFO_WR_ALMOST_FULL_EN to build the registered almost_full flag.
module fifo_wr_ptr_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH),
  parameter int AF_THRESH  = FIFO_DEPTH - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  input  logic              full_comb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   wr_ptr_gray_next,
  output logic [ADDR_W:0]   rd_ptr_gray_sync,
  output logic              full,
  output logic              almost_full
);

  // Reject configurations the gray full comparison cannot represent.
  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (AF_THRESH < 1) || (AF_THRESH > FIFO_DEPTH)) begin : g_bad_cfg
    $error("fifo_wr_ptr_ctrl: illegal FIFO_DEPTH/AF_THRESH");
  end

  logic            accept;
  logic [ADDR_W:0] wr_ptr_bin;
  logic [ADDR_W:0] wr_ptr_bin_next;
  logic [ADDR_W:0] sync1;
  logic [ADDR_W:0] sync2;

  // Reset blocks the strobe so a write racing reset never reaches memory.
  assign accept    = wr_en & ~full & ~rst;
  assign mem_we    = accept;
  assign mem_waddr = wr_ptr_bin[ADDR_W-1:0];

  assign wr_ptr_bin_next  = wr_ptr_bin + {{ADDR_W{1'b0}}, accept};
  assign wr_ptr_gray_next = wr_ptr_bin_next ^ (wr_ptr_bin_next >> 1);
  assign rd_ptr_gray_sync = sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_bin  <= '0;
      wr_ptr_gray <= '0;
      sync1       <= '0;
      sync2       <= '0;
      full        <= 1'b0;
    end else begin
      wr_ptr_bin  <= wr_ptr_bin_next;
      wr_ptr_gray <= wr_ptr_gray_next;
      sync1       <= rd_ptr_gray;
      sync2       <= sync1;
      full        <= full_comb;
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AF_LVL = AF_THRESH[ADDR_W:0];

  logic [ADDR_W:0] rd_bin_sync;
  logic [ADDR_W:0] occ_next;

  // Gray to binary: each bit is the XOR of all gray bits at or above it.
  always_comb begin
    rd_bin_sync = sync2;
    for (int i = ADDR_W - 1; i >= 0; i--)
      rd_bin_sync[i] = rd_bin_sync[i+1] ^ sync2[i];
  end

  assign occ_next = wr_ptr_bin_next - rd_bin_sync;

  always_ff @(posedge clk) begin
    if (rst) almost_full <= 1'b0;
    else     almost_full <= (occ_next >= AF_LVL);
  end
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Self-checking bench: occupancy/count-based reference model of the write side.
module tb_fifo_wr_ptr_ctrl;
  localparam int DEPTH = 16;
  localparam int PW    = 5;
  localparam int AF    = DEPTH - 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [PW-1:0] rd_ptr_gray = '0;
  logic          full_comb;
  logic          mem_we;
  logic [PW-2:0] mem_waddr;
  logic [PW-1:0] wr_ptr_gray, wr_ptr_gray_next, rd_ptr_gray_sync;
  logic          full, almost_full;

  int checks = 0;
  int failures = 0;

  // Reference model: plain counts of writes/reads, sync modelled as a delay line.
  int  wr_total = 0;
  int  rd_cnt   = 0;
  int  s1 = 0, s2 = 0;
  bit  m_full = 1'b0;
  bit  m_af = 1'b0;

  fifo_wr_ptr_ctrl #(.FIFO_DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_ptr_gray(rd_ptr_gray),
    .full_comb(full_comb), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .wr_ptr_gray(wr_ptr_gray), .wr_ptr_gray_next(wr_ptr_gray_next),
    .rd_ptr_gray_sync(rd_ptr_gray_sync), .full(full), .almost_full(almost_full)
  );

  // Downstream full comparator: top two gray bits inverted, rest equal.
  assign full_comb = (wr_ptr_gray_next == {~rd_ptr_gray_sync[PW-1:PW-2], rd_ptr_gray_sync[PW-3:0]});

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] g(input int x);
    logic [PW-1:0] b;
    b = PW'(x % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check outputs, clock, advance model.
  task automatic step(input logic w, input logic r);
    int acc, nxt, occ;
    wr_en = w;
    rst = r;
    rd_ptr_gray = g(rd_cnt);
    #1;
    acc = (w && !m_full && !r) ? 1 : 0;
    check("mem_we", 32'(mem_we), 32'(acc));
    check("mem_waddr", 32'(mem_waddr), 32'(wr_total % DEPTH));
    check("wr_ptr_gray", 32'(wr_ptr_gray), 32'(g(wr_total)));
    check("wr_ptr_gray_next", 32'(wr_ptr_gray_next), 32'(g(wr_total + acc)));
    check("rd_ptr_gray_sync", 32'(rd_ptr_gray_sync), 32'(g(s2)));
    check("full", 32'(full), 32'(m_full));
    check("almost_full", 32'(almost_full), 32'(m_af));
    @(posedge clk);
    if (r) begin
      wr_total = 0; s1 = 0; s2 = 0; m_full = 1'b0; m_af = 1'b0;
    end else begin
      nxt = wr_total + acc;
      occ = nxt - s2;
      m_full = (occ == DEPTH);
`ifdef FIFO_WR_ALMOST_FULL_EN
      m_af = (occ >= AF);
`else
      m_af = 1'b0;
`endif
      s2 = s1;
      s1 = rd_cnt;
      wr_total = nxt;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rd_cnt = 0;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  initial begin
    logic [PW-1:0] prev_g;
    // First edge brings the DUT out of X before any check.
    @(posedge clk);
    @(negedge clk);
    wr_total = 0; s1 = 0; s2 = 0;

    do_reset(2);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);

    // Fill to full with reads stalled.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
    #1;
    check("fill_full", 32'(full), 32'd1);
    check("fill_gray", 32'(wr_ptr_gray), 32'b11000);

    // Overflow attempts are dropped.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    #1;
    check("ovf_gray", 32'(wr_ptr_gray), 32'b11000);

    // One read frees a slot; full releases three edges later.
    rd_cnt = 1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    #1;
    check("drain_full", 32'(full), 32'd0);
    step(1'b1, 1'b0);

    // Wrap with reads keeping pace; gray moves one bit per edge.
    do_reset(1);
    prev_g = wr_ptr_gray;
    for (int i = 0; i < 40; i++) begin
      rd_cnt = wr_total;
      step(1'b1, 1'b0);
      check("gray_1bit", 32'($countones(prev_g ^ wr_ptr_gray)), 32'd1);
      prev_g = wr_ptr_gray;
    end

    // Randomized traffic; reads never overtake writes.
    for (int i = 0; i < 300; i++) begin
      if (rd_cnt < wr_total && ($urandom_range(0, 99) < 45)) rd_cnt++;
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, 1'b0);
    end

    // Reset mid-write.
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    rd_cnt = 0;
    step(1'b1, 1'b1);
    #1;
    check("rst_mid_gray", 32'(wr_ptr_gray), 32'd0);
    check("rst_mid_waddr", 32'(mem_waddr), 32'd0);

    // Almost-full window then release by three reads.
    for (int i = 0; i < AF; i++) step(1'b1, 1'b0);
    rd_cnt = 3;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end
endmodule
